uart_rx_controller: RTL and testbench

UART_RX_CONTROLLER -- requirements
Module: uart_rx_controller

---
 rtl/uart_rx_controller.sv | 204 ++++++++++++++++++++
 tb/tb_uart_rx_controller.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_controller.sv
// UART receive controller: handshakes bytes from a UART receiver into a FIFO and exposes DATA/STATUS registers.
// Optional feature macro: UART_RX_OVR_COUNT_EN adds a saturating overrun counter in STATUS[23:16].
module uart_rx_controller #(
  parameter int DEPTH = 8
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        Rx_Rdy,
  input  logic [7:0]  Rx_Data,
  output logic        Rx_Clr,
  input  logic        Reg_Sel,
  input  logic        ReadEnable,
  input  logic        WriteEnable,
  input  logic [31:0] Data_In,
  output logic [31:0] Data_Out,
  output logic        Rx_Irq
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_CLEAR   = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic           rx_clr_q, rx_clr_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           ovr_q, ovr_d;
  logic           irq_q, irq_d;
  logic [31:0]    data_out_q, data_out_d;
  logic [7:0]     mem_q [DEPTH];

  logic           push_s;
  logic           pop_s;
  logic           wr_en_s;
  logic           empty_s;
  logic           full_s;
  logic           ovr_set_s;
  logic           ovr_clr_s;
  logic [31:0]    status_s;
  logic           data_in_unused_s;

`ifdef UART_RX_OVR_COUNT_EN
  logic [7:0]     ovr_cnt_q, ovr_cnt_d;
`endif

  assign data_in_unused_s = ^{Data_In[31:3], Data_In[1:0]};

  // UART handshake next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (Rx_Rdy) begin
          state_d = ST_CAPTURE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CAPTURE: state_d = ST_CLEAR;
      ST_CLEAR: begin
        if (!Rx_Rdy) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    rx_clr_d = (state_d == ST_CLEAR);
  end

  // FIFO control: a pop frees the slot before a same-cycle push is judged
  always_comb begin
    push_s    = (state_q == ST_CAPTURE);
    empty_s   = (count_q == {CW{1'b0}});
    full_s    = (count_q == FULL_CNT);
    pop_s     = ReadEnable & ~Reg_Sel & ~empty_s;
    wr_en_s   = push_s & (~full_s | pop_s);
    ovr_set_s = push_s & full_s & ~pop_s;
    ovr_clr_s = WriteEnable & Reg_Sel & Data_In[2];

    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({wr_en_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (ovr_set_s) begin
      ovr_d = 1'b1;
    end else if (ovr_clr_s) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end

    irq_d = (count_d != {CW{1'b0}});
  end

`ifdef UART_RX_OVR_COUNT_EN
  // Saturating overrun counter; an increment beats a same-cycle clear
  always_comb begin
    if (ovr_set_s) begin
      if (ovr_cnt_q != 8'hFF) begin
        ovr_cnt_d = ovr_cnt_q + 8'd1;
      end else begin
        ovr_cnt_d = ovr_cnt_q;
      end
    end else if (ovr_clr_s) begin
      ovr_cnt_d = 8'h00;
    end else begin
      ovr_cnt_d = ovr_cnt_q;
    end
  end

  // Overrun counter register
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      ovr_cnt_q <= 8'h00;
    end else begin
      ovr_cnt_q <= ovr_cnt_d;
    end
  end
`endif

  // CPU read path: STATUS snapshot and DATA head byte
  always_comb begin
    status_s       = 32'h0000_0000;
    status_s[0]    = ~empty_s;
    status_s[1]    = full_s;
    status_s[2]    = ovr_q;
    status_s[15:8] = 8'(count_q);
`ifdef UART_RX_OVR_COUNT_EN
    status_s[23:16] = ovr_cnt_q;
`else
    status_s[23:16] = 8'h00;
`endif

    if (ReadEnable) begin
      if (Reg_Sel) begin
        data_out_d = status_s;
      end else if (empty_s) begin
        data_out_d = 32'h0000_0000;
      end else begin
        data_out_d = {24'h00_0000, mem_q[rd_ptr_q]};
      end
    end else begin
      data_out_d = data_out_q;
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read
  always_ff @(posedge Clock) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= Rx_Data;
    end
  end

  // Control and output registers
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= ST_IDLE;
      rx_clr_q   <= 1'b0;
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      count_q    <= {CW{1'b0}};
      ovr_q      <= 1'b0;
      irq_q      <= 1'b0;
      data_out_q <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      rx_clr_q   <= rx_clr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovr_q      <= ovr_d;
      irq_q      <= irq_d;
      data_out_q <= data_out_d;
    end
  end

  assign Rx_Clr   = rx_clr_q;
  assign Rx_Irq   = irq_q;
  assign Data_Out = data_out_q;

endmodule

// File: tb/tb_uart_rx_controller.sv
// Directed self-checking bench for uart_rx_controller with a byte scoreboard queue.
module tb_uart_rx_controller;

  logic        Clock;
  logic        Reset_n;
  logic        Rx_Rdy;
  logic [7:0]  Rx_Data;
  logic        Rx_Clr;
  logic        Reg_Sel;
  logic        ReadEnable;
  logic        WriteEnable;
  logic [31:0] Data_In;
  logic [31:0] Data_Out;
  logic        Rx_Irq;

  int total = 0;
  int bad   = 0;
  logic [7:0] sb[$];

  uart_rx_controller #(.DEPTH(8)) dut (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .Rx_Rdy     (Rx_Rdy),
    .Rx_Data    (Rx_Data),
    .Rx_Clr     (Rx_Clr),
    .Reg_Sel    (Reg_Sel),
    .ReadEnable (ReadEnable),
    .WriteEnable(WriteEnable),
    .Data_In    (Data_In),
    .Data_Out   (Data_Out),
    .Rx_Irq     (Rx_Irq)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] st(input int cnt, input bit ovr, input int ocnt);
    logic [31:0] v;
    v        = 32'h0000_0000;
    v[0]     = (cnt != 0);
    v[1]     = (cnt == 8);
    v[2]     = ovr;
    v[15:8]  = cnt[7:0];
`ifdef UART_RX_OVR_COUNT_EN
    v[23:16] = ocnt[7:0];
`else
    v[23:16] = 8'h00 & ocnt[7:0];
`endif
    return v;
  endfunction

  task automatic wait_clr(input logic lvl);
    int n;
    n = 0;
    while (Rx_Clr !== lvl && n < 20) begin
      step();
      n++;
    end
    check("rx_clr_wait", {31'h0, Rx_Clr}, {31'h0, lvl});
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stored);
    Rx_Data = b;
    Rx_Rdy  = 1'b1;
    if (stored) sb.push_back(b);
    wait_clr(1'b1);
    Rx_Rdy = 1'b0;
    wait_clr(1'b0);
  endtask

  task automatic read_data();
    logic [31:0] exp;
    ReadEnable = 1'b1;
    Reg_Sel    = 1'b0;
    step();
    ReadEnable = 1'b0;
    if (sb.size() == 0) exp = 32'h0;
    else exp = {24'h0, sb.pop_front()};
    check("data_read", Data_Out, exp);
  endtask

  task automatic read_status(input logic [31:0] exp);
    ReadEnable = 1'b1;
    Reg_Sel    = 1'b1;
    step();
    ReadEnable = 1'b0;
    Reg_Sel    = 1'b0;
    check("status_read", Data_Out, exp);
  endtask

  task automatic write_reg(input logic sel, input logic [31:0] val);
    WriteEnable = 1'b1;
    Reg_Sel     = sel;
    Data_In     = val;
    step();
    WriteEnable = 1'b0;
    Reg_Sel     = 1'b0;
    Data_In     = 32'h0;
  endtask

  initial begin
    Reset_n = 1'b1; Rx_Rdy = 1'b0; Rx_Data = 8'h00; Reg_Sel = 1'b0;
    ReadEnable = 1'b0; WriteEnable = 1'b0; Data_In = 32'h0;
    #1 Reset_n = 1'b0;
    #1;
    check("reset_data_out", Data_Out, 32'h0);
    check("reset_rx_clr", {31'h0, Rx_Clr}, 32'h0);
    check("reset_irq", {31'h0, Rx_Irq}, 32'h0);
    repeat (2) @(posedge Clock);
    #2 Reset_n = 1'b1;
    step();

    // two bytes in, two DATA reads out
    send_byte(8'h41, 1'b1);
    send_byte(8'h42, 1'b1);
    check("irq_nonempty", {31'h0, Rx_Irq}, 32'h1);
    read_data();
    read_data();
    check("irq_after_drain", {31'h0, Rx_Irq}, 32'h0);

    // Rx_Rdy held 10 cycles: one push, Rx_Clr from cycle after CAPTURE
    Rx_Data = 8'h55;
    Rx_Rdy  = 1'b1;
    sb.push_back(8'h55);
    for (int k = 1; k <= 10; k++) begin
      step();
      check("clr_held", {31'h0, Rx_Clr}, (k >= 2) ? 32'h1 : 32'h0);
    end
    Rx_Rdy = 1'b0;
    step();
    check("clr_drop", {31'h0, Rx_Clr}, 32'h0);
    read_status(st(1, 1'b0, 0));
    read_data();
    repeat (3) step();
    check("data_out_hold", Data_Out, 32'h0000_0055);

    // empty DATA read
    read_data();
    read_status(st(0, 1'b0, 0));

    // nine bytes into depth 8: ninth lost, OVR set
    for (int i = 0; i < 9; i++) send_byte(8'h10 + 8'(i), (i < 8));
`ifdef UART_RX_OVR_COUNT_EN
    read_status(32'h0001_0807);
`else
    read_status(32'h0000_0807);
`endif
    write_reg(1'b1, 32'h0000_0004);
    read_status(st(8, 1'b0, 0));

    // full FIFO: push and DATA read in the same cycle
    Rx_Data = 8'h99;
    Rx_Rdy  = 1'b1;
    step();
    ReadEnable = 1'b1;
    Reg_Sel    = 1'b0;
    step();
    ReadEnable = 1'b0;
    check("full_push_pop_data", Data_Out, {24'h0, sb.pop_front()});
    sb.push_back(8'h99);
    Rx_Rdy = 1'b0;
    wait_clr(1'b0);
    read_status(st(8, 1'b0, 0));
    for (int i = 0; i < 8; i++) read_data();
    check("irq_empty_again", {31'h0, Rx_Irq}, 32'h0);

    // empty FIFO: push and DATA read in the same cycle, no bypass
    Rx_Data = 8'hA5;
    Rx_Rdy  = 1'b1;
    step();
    ReadEnable = 1'b1;
    Reg_Sel    = 1'b0;
    step();
    ReadEnable = 1'b0;
    check("empty_push_read", Data_Out, 32'h0);
    Rx_Rdy = 1'b0;
    wait_clr(1'b0);
    read_status(st(1, 1'b0, 0));
    sb.push_back(8'hA5);
    read_data();

    // overrun and OVR clear in the same cycle: set wins
    for (int i = 0; i < 8; i++) send_byte(8'h20 + 8'(i), 1'b1);
    Rx_Data = 8'hEE;
    Rx_Rdy  = 1'b1;
    step();
    write_reg(1'b1, 32'h0000_0004);
    Rx_Rdy = 1'b0;
    wait_clr(1'b0);
    read_status(st(8, 1'b1, 1));
    write_reg(1'b0, 32'h0000_0004);
    write_reg(1'b1, 32'hFFFF_FFFB);
    read_status(st(8, 1'b1, 1));
    for (int i = 0; i < 5; i++) read_data();
    read_status(st(3, 1'b1, 1));

    // reset while in CLEAR with 3 bytes queued
    Rx_Data = 8'h77;
    Rx_Rdy  = 1'b1;
    step();
    step();
    check("pre_reset_clr", {31'h0, Rx_Clr}, 32'h1);
    Reset_n = 1'b0;
    #1;
    check("async_reset_data_out", Data_Out, 32'h0);
    check("async_reset_rx_clr", {31'h0, Rx_Clr}, 32'h0);
    check("async_reset_irq", {31'h0, Rx_Irq}, 32'h0);
    sb.delete();
    @(posedge Clock);
    #2 Reset_n = 1'b1;
    read_status(st(0, 1'b0, 0));
    sb.push_back(8'h77);
    wait_clr(1'b1);
    Rx_Rdy = 1'b0;
    wait_clr(1'b0);
    read_status(st(1, 1'b0, 0));
    read_data();
    check("final_irq", {31'h0, Rx_Irq}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
